// File: rtl/kbd_scancode_ctrl.sv
// kbd_scancode_ctrl: turns raw PS/2 scan-code bytes into key events.
// E0 (extended) and F0 (break) prefixes are stripped and folded into ext/make
// flags. Events are queued in a small show-ahead FIFO with a valid/ready port.
// A watchdog returns a half-received prefix sequence to IDLE if the keyboard stalls.
module kbd_scancode_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    din,
    input  logic                          din_new,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_make,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          seq_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q, seq_err_q;
    logic [9:0]        mem_q [FIFO_DEPTH];

    logic              is_e0, is_f0, is_bad;
    logic              timeout_hit;
    logic              push, push_ext, push_make, err_d;
    logic              pop, full, accept, ovf_d;
    logic [9:0]        head;

    assign is_e0  = (din == BYTE_E0);
    assign is_f0  = (din == BYTE_F0);
    // 00 and FF are keyboard error/overrun codes, never valid key codes.
    assign is_bad = (din == 8'h00) || (din == 8'hFF);

    // A byte arriving on the same cycle as the deadline takes priority.
    assign timeout_hit = (state_q != IDLE) && !din_new &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Decode the incoming byte against the prefix collected so far.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_make = 1'b0;
        err_d     = 1'b0;
        if (din_new) begin
            case (state_q)
                IDLE: begin
                    if (is_e0)       state_d = GOT_E0;
                    else if (is_f0)  state_d = GOT_F0;
                    else if (is_bad) err_d   = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    state_d = IDLE;
                    if (is_f0)                state_d = GOT_E0F0;
                    else if (is_e0 || is_bad) err_d   = 1'b1;
                    else begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        push_make = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_d = IDLE;
                    if (is_e0 || is_f0 || is_bad) err_d = 1'b1;
                    else push = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    if (is_e0 || is_f0 || is_bad) err_d = 1'b1;
                    else begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // Watchdog counts idle cycles only while part-way through a sequence.
    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (din_new || (state_q == IDLE)) to_cnt_d = '0;
    end

    // FIFO control: a pop frees the slot a simultaneous push needs when full.
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid && ev_ready;
    assign accept   = push && (!full || pop);
    assign ovf_d    = push && full && !pop;

    // Sequencer state, watchdog, pointers and the registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            overflow_q <= ovf_d;
            seq_err_q  <= err_d;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(accept) - CW'(pop);
        end
    end

    // Event storage: one register per slot, written when the write pointer selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        // Capture {code, ext, make} into this slot on an accepted push.
        always_ff @(posedge clk) begin
            if (accept && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= {din, push_ext, push_make};
            end
        end
    end

    // Show-ahead head; fields are forced to zero when nothing is queued.
    assign head     = ev_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign ev_code  = head[9:2];
    assign ev_ext   = head[1];
    assign ev_make  = head[0];
    assign ev_count = count_q;
    assign overflow = overflow_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_kbd_scancode_ctrl.sv
// Bench for kbd_scancode_ctrl: directed byte sequences, a queue-based event
// model checked every cycle, and literal expectations at key points.
module tb_kbd_scancode_ctrl;

    localparam int D  = 4;
    localparam int T  = 12;
    localparam int TW = 16;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    din = 8'h00;
    logic          din_new = 1'b0;
    logic          ev_ready = 1'b0;
    logic [7:0]    ev_code;
    logic          ev_ext, ev_make, ev_valid, overflow, seq_err;
    logic [CW-1:0] ev_count;

    kbd_scancode_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
        .clk(clk), .reset(reset), .din(din), .din_new(din_new),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_make(ev_make),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_count(ev_count),
        .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
    } ev_t;

    ev_t        mq[$];
    logic [7:0] pre[$];
    int         cyc = 0;
    int         last_cyc = 0;
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        ev_t  nev;
        logic has_ev;
        logic bad;
        logic do_pop;
        ev_t  hd;
        cyc++;
        if (reset) begin
            mq.delete();
            pre.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
        end else begin
            do_pop = (mq.size() > 0) && ev_ready;
            has_ev = 1'b0;
            nev    = '0;
            m_err  = 1'b0;
            m_ovf  = 1'b0;
            if (din_new) begin
                last_cyc = cyc;
                bad = (din == 8'h00) || (din == 8'hFF);
                if (pre.size() == 0) begin
                    if (din == 8'hE0 || din == 8'hF0) pre.push_back(din);
                    else if (bad) m_err = 1'b1;
                    else begin has_ev = 1'b1; nev = '{din, 1'b0, 1'b1}; end
                end else if (pre.size() == 1 && pre[0] == 8'hE0) begin
                    if (din == 8'hF0) pre.push_back(din);
                    else begin
                        if (din == 8'hE0 || bad) m_err = 1'b1;
                        else begin has_ev = 1'b1; nev = '{din, 1'b1, 1'b1}; end
                        pre.delete();
                    end
                end else begin
                    // a break prefix has been seen; only a real key code may follow
                    if (din == 8'hE0 || din == 8'hF0 || bad) m_err = 1'b1;
                    else begin has_ev = 1'b1; nev = '{din, pre[0] == 8'hE0, 1'b0}; end
                    pre.delete();
                end
            end else if (pre.size() > 0 && (cyc - last_cyc) == T) begin
                m_err = 1'b1;
                pre.delete();
            end
            if (do_pop) void'(mq.pop_front());
            if (has_ev) begin
                if (mq.size() < D) mq.push_back(nev);
                else m_ovf = 1'b1;
            end
        end
        #1;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk("cyc_valid",    ev_valid, mq.size() > 0);
        chk("cyc_count",    ev_count, mq.size());
        chk("cyc_code",     ev_code,  hd.code);
        chk("cyc_ext",      ev_ext,   hd.ext);
        chk("cyc_make",     ev_make,  hd.make);
        chk("cyc_overflow", overflow, m_ovf);
        chk("cyc_seq_err",  seq_err,  m_err);
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic send(input logic [7:0] b);
        din = b; din_new = 1'b1;
        @(negedge clk);
        din_new = 1'b0; din = 8'h00;
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic head_is(input string nm, input logic [7:0] c, input logic x, input logic m);
        chk({nm, "_code"}, ev_code, c);
        chk({nm, "_ext"},  ev_ext,  x);
        chk({nm, "_make"}, ev_make, m);
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_valid"}, ev_valid, 0);
        chk({nm, "_count"}, ev_count, 0);
        chk({nm, "_ovf"},   overflow, 0);
        chk({nm, "_err"},   seq_err,  0);
        head_is(nm, 8'h00, 1'b0, 1'b0);
    endtask

    logic [7:0] ov_codes [5];
    logic [7:0] sim_codes [5];

    initial begin
        ov_codes  = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
        sim_codes = '{8'h21, 8'h22, 8'h23, 8'h2A, 8'h2B};

        reset = 1'b1;
        idle(3);
        all_zero("reset");
        reset = 1'b0;
        idle(1);

        // single make code
        send(8'h1C);
        chk("single_valid", ev_valid, 1);
        chk("single_count", ev_count, 1);
        head_is("single", 8'h1C, 1'b0, 1'b1);
        pop1();
        chk("single_popped_count", ev_count, 0);
        chk("single_popped_valid", ev_valid, 0);
        chk("single_popped_code",  ev_code, 0);

        // break and extended-break
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("brk_count", ev_count, 2);
        chk("brk_err",   seq_err, 0);
        head_is("brk1", 8'h1C, 1'b0, 1'b0);
        pop1();
        head_is("brk2", 8'h75, 1'b1, 1'b0);
        pop1();

        // overflow with consumer stalled
        for (int i = 0; i < 5; i++) send(ov_codes[i]);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", ev_count, 4);
        idle(1);
        chk("ovf_pulse_end", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            head_is($sformatf("ovf_drain%0d", i), ov_codes[i], 1'b0, 1'b1);
            pop1();
        end
        chk("ovf_empty", ev_count, 0);

        // full FIFO: push and pop on the same edge
        for (int i = 0; i < 4; i++) send(sim_codes[i]);
        ev_ready = 1'b1; din = sim_codes[4]; din_new = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0; din_new = 1'b0; din = 8'h00;
        chk("sim_count", ev_count, 4);
        chk("sim_ovf",   overflow, 0);
        for (int i = 1; i < 5; i++) begin
            head_is($sformatf("sim_drain%0d", i), sim_codes[i], 1'b0, 1'b1);
            pop1();
        end

        // timeout after a lone E0
        send(8'hE0);
        idle(T - 1);
        chk("to_not_yet", seq_err, 0);
        idle(1);
        chk("to_pulse", seq_err, 1);
        chk("to_count", ev_count, 0);
        send(8'h1C);
        head_is("to_after", 8'h1C, 1'b0, 1'b1);
        pop1();

        // byte on the deadline cycle beats the timeout
        send(8'hE0);
        idle(T - 1);
        send(8'h74);
        chk("to_edge_err", seq_err, 0);
        head_is("to_edge", 8'h74, 1'b1, 1'b1);
        pop1();

        // illegal sequences
        send(8'hF0); send(8'hE0);
        chk("f0e0_err",   seq_err, 1);
        chk("f0e0_count", ev_count, 0);
        send(8'hE0); send(8'h00);
        chk("e000_err", seq_err, 1);
        send(8'hFF);
        chk("ff_idle_err", seq_err, 1);
        send(8'h1C);
        chk("ff_recover_err", seq_err, 0);
        head_is("ff_recover", 8'h1C, 1'b0, 1'b1);

        // reset mid-sequence with FIFO occupied
        send(8'hE0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        all_zero("midreset");
        send(8'h1C);
        head_is("post_reset", 8'h1C, 1'b0, 1'b1);
        pop1();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
